// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART blocks (transmitter now, receiver later).
package uart_pkg;

    localparam int unsigned DEF_DATA_BITS  = 8;
    localparam int unsigned DEF_FIFO_DEPTH = 4;
    localparam int unsigned DEF_DIV_WIDTH  = 16;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_ODD  = 2'b01,
        PAR_EVEN = 2'b10
    } parity_mode_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // The unused encoding 2'b11 behaves as no parity.
    function automatic parity_mode_t decode_parity(input logic [1:0] mode);
        parity_mode_t result;
        case (mode)
            2'b01:   result = PAR_ODD;
            2'b10:   result = PAR_EVEN;
            default: result = PAR_NONE;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered in_ready; a push while full is ignored.
module sync_fifo #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic [DATA_BITS-1:0]         push_data,
    input  logic                         pop,
    output logic [DATA_BITS-1:0]         head,
    output logic [$clog2(FIFO_DEPTH):0]  level,
    output logic                         in_ready
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        level_q, level_d;
    logic                 in_ready_q, in_ready_d;
    logic                 do_push, do_pop;

    always_comb begin
        do_push    = push && in_ready_q;
        do_pop     = pop && (level_q != '0);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (do_push && !do_pop)      level_d = level_q + LW'(1);
        else if (!do_push && do_pop) level_d = level_q - LW'(1);
        in_ready_d = (level_d != LW'(FIFO_DEPTH));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            in_ready_q <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head     = mem_q[rd_ptr_q];
    assign level    = level_q;
    assign in_ready = in_ready_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-fed UART transmitter with per-frame latched configuration.
// Optional line break generation is enabled by defining UART_TX_BREAK_EN.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned DIV_WIDTH  = DEF_DIV_WIDTH
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [DIV_WIDTH-1:0]         baud_div,
    input  logic [1:0]                   parity_mode,
    input  logic                         two_stop,
`ifdef UART_TX_BREAK_EN
    input  logic                         send_break,
`endif
    input  logic [DATA_BITS-1:0]         in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         txd,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

    localparam int unsigned BCW = $clog2(DATA_BITS + 2);
    localparam logic [BCW-1:0] BC_DATA  = BCW'(DATA_BITS - 1);
    localparam logic [BCW-1:0] BC_BREAK = BCW'(DATA_BITS + 1);

    tx_state_t            state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [BCW-1:0]       bitcnt_q, bitcnt_d;
    parity_mode_t         par_q, par_d;
    logic                 par_bit_q, par_bit_d;
    logic                 two_stop_q, two_stop_d;
    logic                 stop2_q, stop2_d;
    logic                 txd_q, txd_d;
`ifdef UART_TX_BREAK_EN
    logic                 brk_pend_q, brk_pend_d;
`endif
    logic [DATA_BITS-1:0] head;
    logic                 pop, launch, bit_end;

    sync_fifo #(
        .DATA_BITS  (DATA_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (pop),
        .head      (head),
        .level     (fifo_level),
        .in_ready  (in_ready)
    );

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        div_d      = div_q;
        cnt_d      = cnt_q;
        bitcnt_d   = bitcnt_q;
        par_d      = par_q;
        par_bit_d  = par_bit_q;
        two_stop_d = two_stop_q;
        stop2_d    = stop2_q;
        pop        = 1'b0;
        launch     = 1'b0;
        bit_end    = (cnt_q == '0);
`ifdef UART_TX_BREAK_EN
        brk_pend_d = brk_pend_q || send_break;
`endif
        if (state_q != IDLE) cnt_d = bit_end ? div_q : cnt_q - DIV_WIDTH'(1);

        unique case (state_q)
            IDLE:  launch = 1'b1;
            START: if (bit_end) state_d = DATA;
            DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (bitcnt_q == '0) begin
                        state_d = (par_q == PAR_NONE) ? STOP : PARITY;
                        stop2_d = two_stop_q;
                    end else begin
                        bitcnt_d = bitcnt_q - BCW'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    stop2_d = two_stop_q;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop2_q) begin
                        stop2_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                        launch  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Launch is shared by IDLE and the last stop clock so frames run back-to-back.
        if (launch) begin
`ifdef UART_TX_BREAK_EN
            if (brk_pend_q || send_break) begin
                state_d    = START;
                shreg_d    = '0;
                div_d      = baud_div;
                cnt_d      = baud_div;
                bitcnt_d   = BC_BREAK;
                par_d      = PAR_NONE;
                two_stop_d = 1'b0;
                brk_pend_d = 1'b0;
            end else
`endif
            if (fifo_level != '0) begin
                pop        = 1'b1;
                state_d    = START;
                shreg_d    = head;
                div_d      = baud_div;
                cnt_d      = baud_div;
                bitcnt_d   = BC_DATA;
                par_d      = decode_parity(parity_mode);
                par_bit_d  = (decode_parity(parity_mode) == PAR_ODD) ? ~^head : ^head;
                two_stop_d = two_stop;
            end
        end

        unique case (state_q)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shreg_q[0];
            PARITY:  txd_d = par_bit_q;
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            div_q      <= '0;
            cnt_q      <= '0;
            bitcnt_q   <= '0;
            par_q      <= PAR_NONE;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            stop2_q    <= 1'b0;
            txd_q      <= 1'b1;
`ifdef UART_TX_BREAK_EN
            brk_pend_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            bitcnt_q   <= bitcnt_d;
            par_q      <= par_d;
            par_bit_q  <= par_bit_d;
            two_stop_q <= two_stop_d;
            stop2_q    <= stop2_d;
            txd_q      <= txd_d;
`ifdef UART_TX_BREAK_EN
            brk_pend_q <= brk_pend_d;
`endif
        end
    end

    assign txd  = txd_q;
    assign busy = (state_q != IDLE) || (fifo_level != '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: expected txd waveforms are built from frame rules.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    localparam int unsigned DB    = 8;
    localparam int unsigned DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] baud_div = 16'd3;
    logic [1:0]  parity_mode = 2'b00;
    logic        two_stop = 1'b0;
    logic [DB-1:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready, txd, busy;
    logic [2:0]  fifo_level;
`ifdef UART_TX_BREAK_EN
    logic        send_break = 1'b0;
`endif

    uart_tx_fifo #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .baud_div    (baud_div),
        .parity_mode (parity_mode),
        .two_stop    (two_stop),
`ifdef UART_TX_BREAK_EN
        .send_break  (send_break),
`endif
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .txd         (txd),
        .busy        (busy),
        .fifo_level  (fifo_level)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DB-1:0] data;
        int unsigned   div;
        int unsigned   par;   // 0 none, 1 odd, 2 even
        bit            two;
        bit            brk;
    } exp_t;

    exp_t        sb[$];
    bit          exp_bits[$];
    int unsigned starts[$];
    int unsigned compared = 0, mismatched = 0;
    int unsigned frames_done = 0, cyc = 0, idx = 0, max_level = 0;
    bit          in_frame = 0, unexp = 0, bad_val = 0;
    int          first_bad = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add_bits(input bit b, input int unsigned n);
        repeat (n) exp_bits.push_back(b);
    endtask

    task automatic build_expected(input exp_t e);
        int unsigned per = e.div + 1;
        exp_bits.delete();
        if (e.brk) begin
            add_bits(1'b0, (DB + 3) * per);
            add_bits(1'b1, per);
        end else begin
            add_bits(1'b0, per);
            for (int i = 0; i < DB; i++) add_bits(e.data[i], per);
            if (e.par == 1)      add_bits(($countones(e.data) % 2) == 0, per);
            else if (e.par == 2) add_bits(($countones(e.data) % 2) == 1, per);
            add_bits(1'b1, per);
            if (e.two) add_bits(1'b1, per);
        end
    endtask

    // Monitor: a low txd outside a frame starts the next expected frame.
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            in_frame = 0;
            unexp    = 0;
        end else begin
            cyc++;
            if (fifo_level > max_level) max_level = fifo_level;
            if (!in_frame && txd === 1'b0 && !unexp) begin
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_frame: txd low at clock %0d with nothing queued, expected idle 1", cyc);
                    unexp = 1;
                end else begin
                    e = sb.pop_front();
                    build_expected(e);
                    in_frame  = 1;
                    idx       = 0;
                    first_bad = -1;
                    starts.push_back(cyc);
                    check("busy_at_frame_start", busy, 1);
                end
            end
            if (txd === 1'b1) unexp = 0;
            if (in_frame) begin
                if (txd !== exp_bits[idx] && first_bad < 0) begin
                    first_bad = idx;
                    bad_val   = txd;
                end
                idx++;
                if (idx == exp_bits.size()) begin
                    compared++;
                    if (first_bad >= 0) begin
                        mismatched++;
                        $display("FAIL frame_%0d: txd got %b at clock %0d of frame, expected %b",
                                 frames_done, bad_val, first_bad, exp_bits[first_bad]);
                    end
                    in_frame = 0;
                    frames_done++;
                end
            end
        end
    end

    task automatic push_word(input logic [DB-1:0] d);
        exp_t e;
        int unsigned n = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && n < 400) begin
            @(posedge clock); #1;
            n++;
        end
        check("push_accept", in_ready, 1);
        if (in_ready) begin
            e.data = d;
            e.div  = baud_div;
            e.par  = (parity_mode == 2'b01) ? 1 : (parity_mode == 2'b10) ? 2 : 0;
            e.two  = two_stop;
            e.brk  = 0;
            @(posedge clock);
            sb.push_back(e);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        while (busy && n < 5000) begin
            @(posedge clock); #1;
            n++;
        end
        check("idle_timeout", busy, 0);
        repeat (3) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic wait_frames(input int unsigned target);
        int unsigned n = 0;
        while (frames_done < target && n < 5000) begin
            @(posedge clock); #1;
            n++;
        end
        check("frame_timeout", frames_done >= target, 1);
    endtask

    initial begin
        int unsigned base, sbase, acc, n;
        #1 reset = 1'b1;
        #2;
        check("rst_txd", txd, 1);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_level", fifo_level, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (2) begin
            @(posedge clock); #1;
        end

        // Odd parity, one stop, 0x55, with pop-to-txd latency.
        baud_div = 16'd3; parity_mode = 2'b01; two_stop = 1'b0;
        base = frames_done;
        push_word(8'h55);
        check("lat_level_after_push", fifo_level, 1);
        check("lat_txd_after_push", txd, 1);
        @(posedge clock); #1;
        check("lat_level_after_pop", fifo_level, 0);
        check("lat_txd_at_pop", txd, 1);
        @(posedge clock); #1;
        check("lat_txd_start", txd, 0);
        wait_frames(base + 1);
        @(posedge clock); #1;
        check("busy_after_frame", busy, 0);
        wait_idle();

        // Even parity with two stops, then no parity.
        parity_mode = 2'b10; two_stop = 1'b1;
        push_word(8'h07);
        wait_idle();
        parity_mode = 2'b00; two_stop = 1'b0;
        push_word(8'hFF);
        wait_idle();

        // Back-to-back burst with in_valid held.
        baud_div = 16'd7; parity_mode = 2'b00; two_stop = 1'b0;
        max_level = 0;
        base  = frames_done;
        sbase = starts.size();
        acc   = 0;
        for (int w = 1; w <= 6; w++) begin
            push_word(DB'(w));
            if (frames_done == base) acc++;
            check("ready_vs_level", in_ready, fifo_level != DEPTH);
        end
        wait_idle();
        check("accepted_before_first_end", acc, 5);
        check("max_level", max_level, DEPTH);
        check("burst_frames", starts.size() - sbase, 6);
        for (int i = 1; i < 6 && sbase + i < starts.size(); i++)
            check("burst_gap", starts[sbase + i] - starts[sbase + i - 1], (DB + 2) * 8);

        // Reconfiguration mid-frame: second frame takes the new divider.
        baud_div = 16'd3;
        sbase = starts.size();
        push_word(8'h5A);
        n = 0;
        while (!in_frame && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        check("reconfig_frame_started", in_frame, 1);
        baud_div = 16'd1;
        push_word(8'hC3);
        wait_idle();
        check("reconfig_frames", starts.size() - sbase, 2);
        if (starts.size() >= sbase + 2)
            check("reconfig_gap", starts[sbase + 1] - starts[sbase], (DB + 2) * 4);

        // Reset during DATA with a word still queued.
        baud_div = 16'd3; parity_mode = 2'b00; two_stop = 1'b0;
        push_word(8'h3C);
        push_word(8'h99);
        n = 0;
        while (!(in_frame && idx >= 12) && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        check("reset_reached_data", in_frame && idx >= 12, 1);
        #1 reset = 1'b1;
        #1;
        check("midrst_txd", txd, 1);
        check("midrst_level", fifo_level, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_busy", busy, 0);
        sb.delete();
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        @(posedge clock); #1;
        push_word(8'hA5);
        wait_idle();

        // Randomised configurations and traffic.
        for (int p = 0; p < 6; p++) begin
            baud_div    = 16'($urandom_range(0, 5));
            parity_mode = 2'($urandom_range(0, 3));
            two_stop    = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 7);
            for (int k = 0; k < n; k++) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clock); #1;
                end
                push_word(DB'($urandom_range(0, 255)));
            end
            wait_idle();
        end

`ifdef UART_TX_BREAK_EN
        begin
            exp_t be;
            baud_div = 16'd1; parity_mode = 2'b00; two_stop = 1'b0;
            be.data = '0; be.div = 1; be.par = 0; be.two = 0; be.brk = 1;
            send_break = 1'b1;
            sb.push_back(be);
            push_word(8'h3C);
            send_break = 1'b0;
            repeat (6) begin
                @(posedge clock); #1;
            end
            check("break_level_held", fifo_level, 1);
            check("break_busy", busy, 1);
            wait_idle();
        end
`endif

        check("scoreboard_empty", sb.size(), 0);
        check("no_frame_pending", in_frame, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised UART transmitter with a FIFO front end.
- Accepts words over a valid/ready handshake and buffers them in a FIFO_DEPTH-entry FIFO.
- Serialises each word LSB-first: start bit, DATA_BITS data bits, optional parity bit, then 1 or 2 stop bits.
- Bit period is run-time programmable through a clock divider. The block sits between the clock/display control logic and the board TX pin.

Parameters:
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- FIFO_DEPTH, 4: FIFO entries; power of two, at least 2.
- DIV_WIDTH, 16: width of the baud_div port.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- baud_div  in  DIV_WIDTH  clocks per bit minus 1.
- parity_mode  in  2  00 none, 01 odd, 10 even, 11 none.
- two_stop  in  1  1 selects two stop bits.
- in_data  in  DATA_BITS  word to transmit.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  FIFO can accept a word.
- txd  out  1  serial output; idles high.
- busy  out  1  a frame is in progress or the FIFO is non-empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of FIFO entries.

Behaviour:
- Reset values: txd=1, in_ready=1, busy=0, fifo_level=0, state IDLE, FIFO pointers 0.
- Reset mid-frame aborts the frame: txd returns to 1 asynchronously and the FIFO contents are discarded.
- Handshake:
  - A word is written on a rising clock edge when in_valid && in_ready.
  - in_ready = (fifo_level != FIFO_DEPTH), registered from the level.
  - in_valid while full is ignored; no data is lost from the FIFO.
- Simultaneous push and pop in one cycle: level unchanged, both take effect. Pointers wrap modulo FIFO_DEPTH.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - If the FIFO is non-empty, pop the head into the shift register.
  - Latch baud_div, parity_mode and two_stop; load the bit counter; go to START.
  - Latency: txd falls 1 cycle after the pop edge.
  - Configuration changes mid-frame have no effect until the next frame.
- Bit timing: every bit holds txd for exactly baud_div+1 clocks. baud_div=0 gives one clock per bit.
- START: txd=0, then go to DATA.
- DATA: shift DATA_BITS bits LSB-first. Then go to PARITY if parity_mode is 01 or 10, else to STOP.
- PARITY:
  - odd: bit = ~^data; even: bit = ^data (computed on the latched word).
  - Then go to STOP.
- STOP: txd=1 for 1 or 2 bit periods.
- After the final stop period, go to IDLE. If the FIFO is non-empty at that edge, the next pop happens in the same cycle, so frames run back-to-back with no idle gap.
- busy = (state != IDLE) || (fifo_level != 0).

Optional Feature:
- Macro UART_TX_BREAK_EN.
- When defined:
  - Adds input send_break (1 bit).
  - If send_break is high in IDLE, txd is driven 0 for (DATA_BITS+3)*(baud_div+1) clocks, followed by one stop period of 1.
  - The FIFO is not popped during a break, and busy is high for its duration.
  - send_break seen mid-frame is held off until the frame completes.
- When undefined: the port is absent and the behaviour is as above.

Decomposition:
- Package uart_pkg holds:
  - enum parity_mode_t {PAR_NONE, PAR_ODD, PAR_EVEN}
  - enum tx_state_t (IDLE..STOP)
  - localparam defaults for DATA_BITS and DIV_WIDTH.
- Sub-module sync_fifo: parametrised DATA_BITS x FIFO_DEPTH, with push/pop/level. It is reused later by the receiver.

Test Plan:
- Single frame: baud_div=3, parity 01, one stop bit, push 0x55. Expect txd: 0 for 4 clocks, then 1,0,1,0,1,0,1,0 at 4 clocks each, parity 1, stop 1. Total 44 clocks; busy falls after the last stop clock.
- Even parity with two stops: push 0x07 → parity bit 1 and two stop periods. Then parity 00, push 0xFF → no parity bit, 40-clock frame.
- Back-to-back traffic: hold in_valid with words 0x01..0x06 at baud_div=7. Expect in_ready low when fifo_level=4, exactly 5 words accepted before the first frame ends, and frames contiguous with no idle gap.
- Reconfiguration: change baud_div from 3 to 1 in the middle of a frame. The current frame keeps 4-clock bits; the next frame uses 2-clock bits.
- Reset mid-frame: assert reset during DATA. txd=1 immediately, fifo_level=0, in_ready=1. After release, push 0xA5 and expect a clean frame.
- With UART_TX_BREAK_EN: send_break at baud_div=1 → txd=0 for 22 clocks then 1 for 2 clocks, and fifo_level is unchanged.
